// File: rtl/avalon_sram_ctrl_mw.sv
// Avalon-MM slave to asynchronous SRAM bridge; each Avalon word is split into RATIO SRAM beats.
// Define SRAM_CTRL_TURNAROUND_EN to insert a dead TURN cycle after every write transfer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for avs_read/avs_write; latches the request
// S_ACCESS | running SRAM beats; cnt counts cycles within the current beat
// S_DONE   | waitrequest low for one cycle, SRAM idle
// S_TURN   | (turnaround build only) dead cycle after a write, DQ released
module avalon_sram_ctrl_mw #(
  parameter int SRAM_AW   = 18,
  parameter int SRAM_DW   = 16,
  parameter int RATIO     = 2,
  parameter int AVS_DW    = SRAM_DW * RATIO,
  parameter int AVS_AW    = SRAM_AW - $clog2(RATIO),
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [AVS_AW-1:0]     avs_address,
  input  logic [AVS_DW-1:0]     avs_writedata,
  input  logic [AVS_DW/8-1:0]   avs_byteenable,
  output logic [AVS_DW-1:0]     avs_readdata,
  output logic                  avs_waitrequest,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [SRAM_DW/8-1:0]  sram_be_n,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [SRAM_DW-1:0]    sram_dq_write,
  output logic [SRAM_DW-1:0]    sram_dq_en,
  input  logic [SRAM_DW-1:0]    sram_dq_read
);

  localparam int SB    = SRAM_DW / 8;
  localparam int AB    = AVS_DW / 8;
  localparam int LOG2R = $clog2(RATIO);
  localparam int BW    = (RATIO > 1) ? LOG2R : 1;
  localparam int MAXC  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
`ifdef SRAM_CTRL_TURNAROUND_EN
    , S_TURN = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [AVS_AW-1:0]   addr_lat_q, addr_lat_d;
  logic [AVS_DW-1:0]   wdata_q, wdata_d;
  logic [AB-1:0]       be_q, be_d;
  logic [AVS_DW-1:0]   readdata_q, readdata_d;
  logic                waitreq_q, waitreq_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [SB-1:0]       be_n_q, be_n_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [SRAM_DW-1:0]  dq_write_q, dq_write_d;
  logic [SRAM_DW-1:0]  dq_en_q, dq_en_d;

  logic                skip_cur, beat_end;
  logic [SB-1:0]       be_slice_d;
  logic                skip_d, active_d;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_lat_d = addr_lat_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    readdata_d = readdata_q;
    addr_d     = addr_q;
    dq_write_d = dq_write_q;

    // A write beat with no enabled byte lanes costs a single idle cycle.
    skip_cur = wr_q && (be_q[int'(beat_q)*SB +: SB] == '0);
    beat_end = wr_q ? (skip_cur || (cnt_q == WR_LAST)) : (cnt_q == RD_LAST);

    case (state_q)
      S_IDLE: begin
        if (avs_read || avs_write) begin
          state_d    = S_ACCESS;
          beat_d     = '0;
          cnt_d      = '0;
          wr_d       = avs_write;
          addr_lat_d = avs_address;
          wdata_d    = avs_writedata;
          be_d       = avs_byteenable;
        end
      end
      S_ACCESS: begin
        if (!wr_q && (cnt_q == RD_LAST))
          readdata_d[int'(beat_q)*SRAM_DW +: SRAM_DW] = sram_dq_read;
        if (beat_end) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
            cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
`ifdef SRAM_CTRL_TURNAROUND_EN
        state_d = wr_q ? S_TURN : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every pad signal leaves a flop.
    be_slice_d = be_d[int'(beat_d)*SB +: SB];
    skip_d     = wr_d && (be_slice_d == '0);
    active_d   = (state_d == S_ACCESS) && !skip_d;
    ce_n_d     = !active_d;
    oe_n_d     = !(active_d && !wr_d);
    we_n_d     = !(active_d && wr_d && (cnt_d != WR_LAST));
    dq_en_d    = (active_d && wr_d) ? '1 : '0;
    be_n_d     = (state_d == S_ACCESS) ? ~be_slice_d : '1;
    waitreq_d  = (state_d != S_DONE);
    if (state_d == S_ACCESS) begin
      addr_d = (SRAM_AW'(addr_lat_d) << LOG2R) | SRAM_AW'(beat_d);
      if (active_d && wr_d)
        dq_write_d = wdata_d[int'(beat_d)*SRAM_DW +: SRAM_DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_lat_q <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      readdata_q <= '0;
      waitreq_q  <= 1'b1;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      be_n_q     <= '1;
      addr_q     <= '0;
      dq_write_q <= '0;
      dq_en_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_lat_q <= addr_lat_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      readdata_q <= readdata_d;
      waitreq_q  <= waitreq_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      be_n_q     <= be_n_d;
      addr_q     <= addr_d;
      dq_write_q <= dq_write_d;
      dq_en_q    <= dq_en_d;
    end
  end

  assign avs_readdata    = readdata_q;
  assign avs_waitrequest = waitreq_q;
  assign sram_ce_n       = ce_n_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;
  assign sram_be_n       = be_n_q;
  assign sram_addr       = addr_q;
  assign sram_dq_write   = dq_write_q;
  assign sram_dq_en      = dq_en_q;

endmodule

// File: tb/tb_avalon_sram_ctrl_mw.sv
// Directed bench for avalon_sram_ctrl_mw (RATIO=2, RD_CYCLES=2, WR_CYCLES=3) with a behavioural SRAM.
// Honours SRAM_CTRL_TURNAROUND_EN for the write-then-read gap check.
module tb_avalon_sram_ctrl_mw;
  logic        clk = 1'b0;
  logic        reset;
  logic        avs_read, avs_write;
  logic [16:0] avs_address;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]  sram_be_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_write, sram_dq_en, sram_dq_read;

  logic [15:0] mem [0:(1<<18)-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_sram_ctrl_mw #(
    .SRAM_AW(18), .SRAM_DW(16), .RATIO(2), .RD_CYCLES(2), .WR_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_addr(sram_addr), .sram_dq_write(sram_dq_write),
    .sram_dq_en(sram_dq_en), .sram_dq_read(sram_dq_read)
  );

  assign sram_dq_read = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      for (int l = 0; l < 2; l++)
        if (!sram_be_n[l]) mem[sram_addr][l*8 +: 8] <= sram_dq_write[l*8 +: 8];
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (avs_waitrequest && n < 40);
  endtask

  task automatic test_reset();
    logic [87:0] obs, exp;
    reset = 1'b1; avs_read = 1'b1; avs_write = 1'b0;
    avs_address = 17'h100; avs_writedata = '0; avs_byteenable = 4'hF;
    repeat (3) @(negedge clk);
    obs = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr,
           sram_dq_en, sram_dq_write, avs_readdata};
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 18'h0, 16'h0, 16'h0, 32'h0};
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL reset_values: got %h expected %h", obs, exp);
    end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b001) begin
          errors++; $display("FAIL reset_release_strobe: got %b expected 001", {sram_ce_n, sram_oe_n, sram_we_n});
        end
      end
      if (k == 5) begin
        checks++;
        if (avs_waitrequest !== 1'b0) begin
          errors++; $display("FAIL reset_release_latency: waitrequest %b expected 0", avs_waitrequest);
        end
      end
    end
    avs_read = 1'b0;
  endtask

  task automatic test_write_full();
    logic [55:0] obs, exp;
    logic [19:0] ctl;
    repeat (2) @(negedge clk);
    avs_write = 1'b1; avs_address = 17'h100; avs_writedata = 32'hBEEF1234; avs_byteenable = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      obs = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_dq_en, sram_dq_write};
      exp = {1'b1, 1'b0, 1'b1, ((k-1)%3 == 2), 2'b00, 18'h200 + 18'((k-1)/3), 16'hFFFF,
             (k <= 3) ? 16'h1234 : 16'hBEEF};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL write_full_cycle%0d: got %h expected %h", k, obs, exp);
      end
    end
    @(negedge clk);
    ctl = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_en};
    checks++;
    if (ctl !== {4'b0111, 16'h0}) begin
      errors++; $display("FAIL write_full_done: got %h expected %h", ctl, {4'b0111, 16'h0});
    end
    avs_write = 1'b0;
  endtask

  task automatic test_read();
    logic [39:0] obs, exp;
    logic [19:0] ctl;
    repeat (2) @(negedge clk);
    avs_read = 1'b1; avs_address = 17'h100; avs_byteenable = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      obs = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_dq_en};
      exp = {4'b1001, 2'b00, 18'h200 + 18'((k-1)/2), 16'h0};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL read_cycle%0d: got %h expected %h", k, obs, exp);
      end
    end
    @(negedge clk);
    ctl = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_en};
    checks++;
    if (ctl !== {4'b0111, 16'h0}) begin
      errors++; $display("FAIL read_done: got %h expected %h", ctl, {4'b0111, 16'h0});
    end
    checks++;
    if (avs_readdata !== 32'hBEEF1234) begin
      errors++; $display("FAIL read_data: got %h expected beef1234", avs_readdata);
    end
    avs_read = 1'b0;
    @(negedge clk);
    checks++;
    if ({avs_waitrequest, avs_readdata} !== {1'b1, 32'hBEEF1234}) begin
      errors++; $display("FAIL read_data_hold: got %b %h expected 1 beef1234", avs_waitrequest, avs_readdata);
    end
  endtask

  task automatic test_rw_both();
    logic [55:0] obs, exp;
    logic [19:0] ctl;
    repeat (2) @(negedge clk);
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 17'h020;
    avs_writedata = 32'h55667788; avs_byteenable = 4'b0011;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      obs = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_dq_en, sram_dq_write};
      exp = {1'b1, 1'b0, 1'b1, (k == 3), 2'b00, 18'h040, 16'hFFFF, 16'h7788};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL rw_both_cycle%0d: got %h expected %h", k, obs, exp);
      end
    end
    @(negedge clk);
    ctl = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_en};
    checks++;
    if (ctl !== {4'b1111, 16'h0}) begin
      errors++; $display("FAIL rw_both_skip_last: got %h expected %h", ctl, {4'b1111, 16'h0});
    end
    @(negedge clk);
    checks++;
    if ({avs_waitrequest, avs_readdata} !== {1'b0, 32'hBEEF1234}) begin
      errors++; $display("FAIL rw_both_done: got %b %h expected 0 beef1234", avs_waitrequest, avs_readdata);
    end
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic test_skip();
    logic [55:0] obs, exp;
    logic [19:0] ctl;
    int n;
    repeat (2) @(negedge clk);
    avs_write = 1'b1; avs_address = 17'h080; avs_writedata = 32'hCAFE5678; avs_byteenable = 4'b1100;
    @(negedge clk);
    ctl = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_en};
    checks++;
    if (ctl !== {4'b1111, 16'h0}) begin
      errors++; $display("FAIL skip_beat0: got %h expected %h", ctl, {4'b1111, 16'h0});
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      obs = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_dq_en, sram_dq_write};
      exp = {1'b1, 1'b0, 1'b1, (k == 4), 2'b00, 18'h101, 16'hFFFF, 16'hCAFE};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL skip_beat1_cycle%0d: got %h expected %h", k, obs, exp);
      end
    end
    @(negedge clk);
    checks++;
    if (avs_waitrequest !== 1'b0) begin
      errors++; $display("FAIL skip_latency: waitrequest %b expected 0", avs_waitrequest);
    end
    avs_write = 1'b0;
    repeat (2) @(negedge clk);
    avs_read = 1'b1; avs_byteenable = 4'hF;
    wait_done(n);
    avs_read = 1'b0;
    checks++;
    if (n != 5 || avs_readdata[31:16] !== 16'hCAFE) begin
      errors++; $display("FAIL skip_readback: cycles %0d data %h expected 5 cafe", n, avs_readdata[31:16]);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] ctl;
    logic [87:0] obs, exp;
    repeat (2) @(negedge clk);
    avs_write = 1'b1; avs_address = 17'h040; avs_writedata = 32'h11112222; avs_byteenable = 4'hF;
    repeat (4) @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_we_n, sram_addr} !== {2'b00, 18'h081}) begin
      errors++; $display("FAIL reset_mid_beat1: got %b%b %h expected 00 00081", sram_ce_n, sram_we_n, sram_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    obs = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr,
           sram_dq_en, sram_dq_write, avs_readdata};
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 18'h0, 16'h0, 16'h0, 32'h0};
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL reset_mid_abort: got %h expected %h", obs, exp);
    end
    reset = 1'b0; avs_write = 1'b0;
    avs_read = 1'b1; avs_address = 17'h100;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ctl = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_en};
        checks++;
        if (ctl !== {4'b1001, 16'h0}) begin
          errors++; $display("FAIL reset_mid_reread_start: got %h expected %h", ctl, {4'b1001, 16'h0});
        end
      end
      if (k == 5) begin
        checks++;
        if ({avs_waitrequest, avs_readdata} !== {1'b0, 32'hBEEF1234}) begin
          errors++; $display("FAIL reset_mid_reread: got %b %h expected 0 beef1234", avs_waitrequest, avs_readdata);
        end
      end
    end
    avs_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [19:0] ctl, exp;
`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam int DONE_K = 14;
`else
    localparam int DONE_K = 13;
`endif
    repeat (2) @(negedge clk);
    avs_write = 1'b1; avs_address = 17'h010; avs_writedata = 32'h0A0B0C0D; avs_byteenable = 4'hF;
    repeat (7) @(negedge clk);
    checks++;
    if (avs_waitrequest !== 1'b0) begin
      errors++; $display("FAIL b2b_write_done: waitrequest %b expected 0", avs_waitrequest);
    end
    avs_write = 1'b0; avs_read = 1'b1;
    @(negedge clk);
    ctl = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_en};
    checks++;
    if (ctl !== {4'b1111, 16'h0}) begin
      errors++; $display("FAIL b2b_gap1: got %h expected %h", ctl, {4'b1111, 16'h0});
    end
    @(negedge clk);
    ctl = {avs_waitrequest, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_en};
`ifdef SRAM_CTRL_TURNAROUND_EN
    exp = {4'b1111, 16'h0};
`else
    exp = {4'b1001, 16'h0};
`endif
    checks++;
    if (ctl !== exp) begin
      errors++; $display("FAIL b2b_gap2: got %h expected %h", ctl, exp);
    end
    for (int k = 10; k <= DONE_K; k++) begin
      @(negedge clk);
      checks++;
      if (avs_waitrequest !== (k != DONE_K)) begin
        errors++; $display("FAIL b2b_read_wait_k%0d: got %b expected %b", k, avs_waitrequest, (k != DONE_K));
      end
    end
    checks++;
    if (avs_readdata !== 32'h0A0B0C0D) begin
      errors++; $display("FAIL b2b_read_data: got %h expected 0a0b0c0d", avs_readdata);
    end
    avs_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_read();
    test_rw_both();
    test_skip();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
